// File: rtl/iter_divider_ctrl.sv
// iter_divider_ctrl: sequential restoring divider controller.
// It produces one quotient bit per cycle. It has no subtractor of its own:
// it drives an external WIDTH-bit add/sub unit (a - b) and consumes sum/cout
// in the same cycle. Results come back through a start/busy/done handshake.
// Optional build macro: SIGNED_DIV_EN adds signed division
// (magnitude divide followed by a one-cycle sign fix-up).
module iter_divider_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] add_a,
   output logic [WIDTH-1:0] add_b,
   output logic             add_m,
   output logic             add_cin,
   input  logic [WIDTH-1:0] add_sum,
   input  logic             add_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SIGNED_DIV_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_DONE = 2'd3} state_t;
`endif

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   div_q, div_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   quotient_q, quotient_d;
   logic [WIDTH-1:0]   remainder_q, remainder_d;
   logic               dz_q, dz_d;
   logic               ok;
   logic               fin;
`ifdef SIGNED_DIV_EN
   logic               sgn_q, sgn_d;
   logic               negq_q, negq_d;
   logic               negr_q, negr_d;
`else
   logic               unused_op_signed;
   assign unused_op_signed = op_signed;
`endif

   // State and datapath registers; everything clears on reset, aborting any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rem_q       <= '0;
         quo_q       <= '0;
         div_q       <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dz_q        <= 1'b0;
`ifdef SIGNED_DIV_EN
         sgn_q       <= 1'b0;
         negq_q      <= 1'b0;
         negr_q      <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         div_q       <= div_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dz_q        <= dz_d;
`ifdef SIGNED_DIV_EN
         sgn_q       <= sgn_d;
         negq_q      <= negq_d;
         negr_q      <= negr_d;
`endif
      end
   end

   // Next-state, restoring-divide step and handshake outputs
   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      div_d       = div_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dz_d        = dz_q;
`ifdef SIGNED_DIV_EN
      sgn_d       = sgn_q;
      negq_d      = negq_q;
      negr_d      = negr_q;
`endif
      fin         = 1'b0;
      add_m       = 1'b0;
      add_cin     = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      // Shifted trial remainder; its dropped top bit (rem_q msb) means it already exceeds the divisor
      add_a       = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
      add_b       = div_q;
      ok          = rem_q[WIDTH-1] | add_cout;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (divisor == '0) begin
                  // Divide by zero publishes immediately and takes one DONE cycle
                  state_d     = S_DONE;
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dz_d        = 1'b1;
               end else begin
                  state_d = S_ITER;
                  rem_d   = '0;
                  quo_d   = dividend;
                  div_d   = divisor;
                  cnt_d   = CNT_W'(WIDTH - 1);
`ifdef SIGNED_DIV_EN
                  sgn_d  = op_signed;
                  negq_d = op_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  negr_d = op_signed & dividend[WIDTH-1];
                  if (op_signed && dividend[WIDTH-1]) quo_d = (~dividend) + 1'b1;
                  if (op_signed && divisor[WIDTH-1])  div_d = (~divisor) + 1'b1;
`endif
               end
            end
         end
         S_ITER: begin
            add_m   = 1'b1;
            add_cin = 1'b1;
            busy    = 1'b1;
            rem_d   = ok ? add_sum : add_a;
            quo_d   = {quo_q[WIDTH-2:0], ok};
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == '0) begin
`ifdef SIGNED_DIV_EN
               if (sgn_q) begin
                  state_d = S_FIX;
               end else begin
                  state_d = S_DONE;
                  fin     = 1'b1;
               end
`else
               state_d = S_DONE;
               fin     = 1'b1;
`endif
            end
         end
`ifdef SIGNED_DIV_EN
         S_FIX: begin
            busy    = 1'b1;
            if (negq_q) quo_d = (~quo_q) + 1'b1;
            if (negr_q) rem_d = (~rem_q) + 1'b1;
            state_d = S_DONE;
            fin     = 1'b1;
         end
`endif
         S_DONE: begin
            done    = 1'b1;
            // The divide-by-zero path spends its single busy cycle here
            busy    = dz_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Results are published on entry to DONE so they are valid alongside done
      if (fin) begin
         quotient_d  = quo_d;
         remainder_d = rem_d;
         dz_d        = 1'b0;
      end
   end

   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dz_q;

endmodule

// File: tb/tb_iter_divider_ctrl.sv
// Scoreboard bench for iter_divider_ctrl with an add/sub unit model.
module tb_iter_divider_ctrl;
   localparam int W = 32;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           start_cyc;
      int           lat;
      int           nbusy;
      int           niter;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         op_signed = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic [W-1:0] add_a, add_b, add_sum;
   logic         add_m, add_cin, add_cout;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;
   logic [W:0]   ext;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int busy_cnt = 0;
   int addm_cnt = 0;
   int cin_cnt = 0;
   exp_t exp_q[$];

   iter_divider_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_signed(op_signed),
      .dividend(dividend), .divisor(divisor),
      .add_a(add_a), .add_b(add_b), .add_m(add_m), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Shared add/sub unit: a + (m ? ~b : b) + cin
   always_comb ext = {1'b0, add_a} + {1'b0, (add_m ? ~add_b : add_b)} + {{W{1'b0}}, add_cin};
   assign add_sum  = ext[W-1:0];
   assign add_cout = ext[W];

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic sg);
      exp_t e;
      logic signed [W-1:0] sdd, sdv;
      e.start_cyc = 0;
      sdd = dd;
      sdv = dv;
      if (dv == 0) begin
         e.q = '1; e.r = dd; e.dz = 1'b1; e.lat = 1; e.nbusy = 1; e.niter = 0;
         return e;
      end
      e.dz = 1'b0; e.lat = W + 1; e.nbusy = W; e.niter = W;
      e.q = dd / dv;
      e.r = dd % dv;
`ifdef SIGNED_DIV_EN
      if (sg) begin
         e.lat = W + 2; e.nbusy = W + 1;
         if (dd == {1'b1, {(W-1){1'b0}}} && dv == '1) begin
            e.q = dd; e.r = '0;
         end else begin
            e.q = sdd / sdv;
            e.r = sdd % sdv;
         end
      end
`else
      if (sg) e.lat = W + 1;
`endif
      return e;
   endfunction

   // Present an operation now; optionally keep start high with junk operands while busy
   task automatic do_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic sg, input int hold);
      exp_t e;
      e = model(dd, dv, sg);
      e.start_cyc = cyc;
      exp_q.push_back(e);
      start = 1'b1; dividend = dd; divisor = dv; op_signed = sg;
      @(posedge clk); #1;
      for (int h = 0; h < hold; h++) begin
         dividend = $urandom; divisor = $urandom; op_signed = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   // Wait for done, then return in the following cycle (back-to-back issue point)
   task automatic wait_done();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 200);
      if (!done) begin
         tests++; fails++;
         $display("FAIL timeout: no done after %0d cycles, required done=1", n);
      end
      @(posedge clk); #1;
   endtask

   // Monitor: count busy/iteration cycles and compare each result against the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         busy_cnt = 0; addm_cnt = 0; cin_cnt = 0;
      end else begin
         if (busy)    busy_cnt++;
         if (add_m)   addm_cnt++;
         if (add_cin) cin_cnt++;
         if (done) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_done: done=1 at cycle %0d, required no result", cyc);
            end else begin
               e = exp_q.pop_front();
               chk("quotient", quotient, e.q);
               chk("remainder", remainder, e.r);
               chk("div_by_zero", W'(div_by_zero), W'(e.dz));
               chk("latency", W'(cyc - e.start_cyc), W'(e.lat));
               chk("busy_cycles", W'(busy_cnt), W'(e.nbusy));
               chk("add_m_cycles", W'(addm_cnt), W'(e.niter));
               chk("add_cin_cycles", W'(cin_cnt), W'(e.niter));
            end
            busy_cnt = 0; addm_cnt = 0; cin_cnt = 0;
         end
      end
   end

   initial begin
      logic [W-1:0] dd, dv;
      logic         sg;
      int           sel, hold;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", W'(busy), '0);
      chk("rst_done", W'(done), '0);
      chk("rst_quotient", quotient, '0);
      chk("rst_remainder", remainder, '0);
      chk("rst_dz", W'(div_by_zero), '0);
      chk("rst_add_m", W'(add_m), '0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_op(32'd100, 32'd7, 1'b0, 0);               wait_done();
      do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);         wait_done();
      do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0); wait_done();
      do_op(32'd5, 32'd9, 1'b0, 0);                 wait_done();
      do_op(32'd1234, 32'd0, 1'b0, 0);              wait_done();
      do_op(32'd1000, 32'd3, 1'b0, 5);              wait_done();
      do_op(32'd77, 32'd5, 1'b0, 0);                wait_done();
      do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);         wait_done();
      do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0); wait_done();
      do_op(32'hFFFF_FFF9, 32'd2, 1'b0, 0);         wait_done();
      do_op(32'd17, 32'hFFFF_FFFD, 1'b1, 0);        wait_done();

      // Abort mid-operation with reset
      do_op(32'd999, 32'd4, 1'b0, 0);
      repeat (9) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("abort_busy", W'(busy), '0);
      chk("abort_done", W'(done), '0);
      chk("abort_quotient", quotient, '0);
      chk("abort_remainder", remainder, '0);
      chk("abort_add_m", W'(add_m), '0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      do_op(32'd999, 32'd4, 1'b0, 0);               wait_done();

      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 7);
         dd  = $urandom;
         if (sel == 0)      dv = '0;
         else if (sel < 3)  dv = W'($urandom_range(1, 15));
         else if (sel == 3) dv = '1;
         else               dv = $urandom;
         if ($urandom_range(0, 3) == 0) dd = 32'h8000_0000;
         sg   = 1'($urandom_range(0, 1));
         hold = (dv == '0) ? 0 : $urandom_range(0, 3);
         do_op(dd, dv, sg, hold);
         wait_done();
      end

      repeat (3) @(posedge clk);
      #1;
      chk("pending_results", W'(exp_q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
